// File: rtl/wbus_arbiter_pkg.sv
// Shared types and encodings for the register write-bus arbiter.
// Owner codes, FSM states and the write-bus bundle.
package wbus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OWN_HOST = 3'd1,
    ST_OWN_BW   = 3'd2,
    ST_OWN_RT   = 3'd3,
    ST_TURN     = 3'd4
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_BW   = 2'd2;
  localparam logic [1:0] OWN_RT   = 2'd3;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        reg_wen;
    logic        blk_wen;
    logic        blk_wstart;
  } wbus_t;

  function automatic logic any_strobe(wbus_t b);
    return b.reg_wen | b.blk_wen | b.blk_wstart;
  endfunction

endpackage

// File: rtl/wbus_hold_timer.sv
// Bus-hold watchdog counter for the write-bus arbiter.
// Clear wins over count; saturates at the terminal value.
module wbus_hold_timer #(
  parameter int HOLD_MAX = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(HOLD_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != TC_VAL) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/wbus_arbiter.sv
// Three-way arbiter for the motor-controller register write bus.
// RT > fair(host, bw); registered mux; hold watchdog with sticky flag.
module wbus_arbiter
  import wbus_arbiter_pkg::*;
#(
  parameter int          HOLD_MAX   = 4096,
  parameter logic [7:0]  BW_ADDR_HI = 8'h00,
  parameter logic [11:0] RT_ADDR_HI = 12'h000
) (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic        host_req,
  output logic        host_gnt,
  input  logic [15:0] host_waddr,
  input  logic [31:0] host_wdata,
  input  logic        host_reg_wen,
  input  logic        host_blk_wen,
  input  logic        host_blk_wstart,
  input  logic        bw_req,
  output logic        bw_gnt,
  input  logic [7:0]  bw_waddr,
  input  logic [31:0] bw_wdata,
  input  logic        bw_reg_wen,
  input  logic        bw_blk_wen,
  input  logic        bw_blk_wstart,
  input  logic        rt_req,
  output logic        rt_gnt,
  input  logic [3:0]  rt_waddr,
  input  logic [31:0] rt_wdata,
  input  logic        rt_wen,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_wen,
  output logic        blk_wen,
  output logic        blk_wstart,
  output logic        bw_write_en,
  output logic [1:0]  owner,
  output logic        hold_timeout,
  input  logic        timeout_clr
);

  state_t     state, state_nx;
  logic       last_bw;
  logic [2:0] drop_pend;
  logic [2:0] reqs, elig, own_1hot;
  wbus_t      own_bus, bus_q;
  logic       own_act, own_stb, tmo, enter, tc;

  assign reqs = {rt_req, bw_req, host_req};
  assign elig = reqs & ~drop_pend;

  assign own_1hot = {state == ST_OWN_RT,
                     state == ST_OWN_BW,
                     state == ST_OWN_HOST};

  always_comb begin
    own_bus = '0;
    own_act = 1'b0;
    unique case (1'b1)
      own_1hot[0]: begin
        own_act = host_req;
        own_bus = '{host_waddr, host_wdata, host_reg_wen,
                    host_blk_wen, host_blk_wstart};
      end
      own_1hot[1]: begin
        own_act = bw_req;
        own_bus = '{{BW_ADDR_HI, bw_waddr}, bw_wdata, bw_reg_wen,
                    bw_blk_wen, bw_blk_wstart};
      end
      own_1hot[2]: begin
        own_act = rt_req;
        own_bus = '{{RT_ADDR_HI, rt_waddr}, rt_wdata, rt_wen,
                    1'b0, 1'b0};
      end
      default: ;
    endcase
  end

  assign own_stb = own_act & any_strobe(own_bus);
  // Owner still requesting but silent for the full window: evict it.
  assign tmo     = own_act & tc & ~own_stb;
  assign enter   = (state == ST_IDLE) && (state_nx != ST_IDLE);

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (elig[2])
          state_nx = ST_OWN_RT;
        else if (elig[1] && elig[0])
          state_nx = last_bw ? ST_OWN_HOST : ST_OWN_BW;
        else if (elig[1])
          state_nx = ST_OWN_BW;
        else if (elig[0])
          state_nx = ST_OWN_HOST;
      end
      ST_OWN_HOST, ST_OWN_BW, ST_OWN_RT: begin
        if (!own_act || tmo) state_nx = ST_TURN;
      end
      ST_TURN: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    host_gnt    = 1'b0;
    bw_gnt      = 1'b0;
    rt_gnt      = 1'b0;
    bw_write_en = 1'b0;
    owner       = OWN_NONE;
    unique case (state)
      ST_OWN_HOST: begin
        host_gnt = 1'b1;
        owner    = OWN_HOST;
      end
      ST_OWN_BW: begin
        bw_gnt      = 1'b1;
        bw_write_en = 1'b1;
        owner       = OWN_BW;
      end
      ST_OWN_RT: begin
        rt_gnt = 1'b1;
        owner  = OWN_RT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      last_bw      <= 1'b0;
      drop_pend    <= '0;
      hold_timeout <= 1'b0;
    end else begin
      if (enter && state_nx == ST_OWN_BW)   last_bw <= 1'b1;
      if (enter && state_nx == ST_OWN_HOST) last_bw <= 1'b0;
      drop_pend <= (drop_pend & reqs) | (tmo ? own_1hot : 3'b000);
      if (tmo)              hold_timeout <= 1'b1;
      else if (timeout_clr) hold_timeout <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      bus_q <= '0;
    end else if (own_act) begin
      bus_q <= own_bus;
    end else begin
      bus_q.reg_wen    <= 1'b0;
      bus_q.blk_wen    <= 1'b0;
      bus_q.blk_wstart <= 1'b0;
    end
  end

  assign reg_waddr  = bus_q.addr;
  assign reg_wdata  = bus_q.data;
  assign reg_wen    = bus_q.reg_wen;
  assign blk_wen    = bus_q.blk_wen;
  assign blk_wstart = bus_q.blk_wstart;

  wbus_hold_timer #(
    .HOLD_MAX(HOLD_MAX)
  ) u_hold (
    .clk  (sysclk),
    .rst_n(rstn),
    .clr  (enter | own_stb),
    .en   (own_act),
    .tc   (tc)
  );

endmodule

// File: tb/tb_wbus_arbiter.sv
// Directed self-checking bench for wbus_arbiter.
// Runs with HOLD_MAX=16 so the watchdog window is short.
module tb_wbus_arbiter;

  logic        sysclk = 1'b0;
  logic        rstn;
  logic        host_req, host_gnt;
  logic [15:0] host_waddr;
  logic [31:0] host_wdata;
  logic        host_reg_wen, host_blk_wen, host_blk_wstart;
  logic        bw_req, bw_gnt;
  logic [7:0]  bw_waddr;
  logic [31:0] bw_wdata;
  logic        bw_reg_wen, bw_blk_wen, bw_blk_wstart;
  logic        rt_req, rt_gnt;
  logic [3:0]  rt_waddr;
  logic [31:0] rt_wdata;
  logic        rt_wen;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen, blk_wen, blk_wstart;
  logic        bw_write_en;
  logic [1:0]  owner;
  logic        hold_timeout, timeout_clr;

  int checks = 0;
  int errors = 0;

  always #5 sysclk = ~sysclk;

  wbus_arbiter #(.HOLD_MAX(16)) dut (
    .sysclk(sysclk), .rstn(rstn),
    .host_req(host_req), .host_gnt(host_gnt),
    .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_reg_wen(host_reg_wen), .host_blk_wen(host_blk_wen),
    .host_blk_wstart(host_blk_wstart),
    .bw_req(bw_req), .bw_gnt(bw_gnt),
    .bw_waddr(bw_waddr), .bw_wdata(bw_wdata),
    .bw_reg_wen(bw_reg_wen), .bw_blk_wen(bw_blk_wen),
    .bw_blk_wstart(bw_blk_wstart),
    .rt_req(rt_req), .rt_gnt(rt_gnt),
    .rt_waddr(rt_waddr), .rt_wdata(rt_wdata), .rt_wen(rt_wen),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_wen(reg_wen), .blk_wen(blk_wen), .blk_wstart(blk_wstart),
    .bw_write_en(bw_write_en), .owner(owner),
    .hold_timeout(hold_timeout), .timeout_clr(timeout_clr)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    host_req = 0; host_waddr = '0; host_wdata = '0;
    host_reg_wen = 0; host_blk_wen = 0; host_blk_wstart = 0;
    bw_req = 0; bw_waddr = '0; bw_wdata = '0;
    bw_reg_wen = 0; bw_blk_wen = 0; bw_blk_wstart = 0;
    rt_req = 0; rt_waddr = '0; rt_wdata = '0; rt_wen = 0;
    timeout_clr = 0;
    tick(); tick();
    checks++;
    if ({host_gnt, bw_gnt, rt_gnt, bw_write_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnts got %b want 0000",
               {host_gnt, bw_gnt, rt_gnt, bw_write_en});
    end
    checks++;
    if ({owner, reg_wen, blk_wen, blk_wstart, hold_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 000000",
               {owner, reg_wen, blk_wen, blk_wstart, hold_timeout});
    end
    checks++;
    if (reg_waddr !== 16'h0 || reg_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h want 0/0", reg_waddr, reg_wdata);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_host();
    host_req = 1;
    tick();
    checks++;
    if (host_gnt !== 1'b1 || owner !== 2'd1) begin
      errors++;
      $display("FAIL host_gnt got %b/%0d want 1/1", host_gnt, owner);
    end
    host_waddr = 16'h0012; host_wdata = 32'hDEADBEEF; host_reg_wen = 1;
    tick();
    checks++;
    if (reg_wen !== 1'b1 || reg_waddr !== 16'h0012 ||
        reg_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL host_write got %b %h %h want 1 0012 deadbeef",
               reg_wen, reg_waddr, reg_wdata);
    end
    host_reg_wen = 0;
    tick();
    checks++;
    if (reg_wen !== 1'b0 || reg_waddr !== 16'h0012) begin
      errors++;
      $display("FAIL host_pulse got %b %h want 0 0012", reg_wen, reg_waddr);
    end
    host_req = 0;
    tick();
    checks++;
    if (host_gnt !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL host_release got %b/%0d want 0/0", host_gnt, owner);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic exp_bw;
    host_req = 1; bw_req = 1;
    for (int i = 0; i < 4; i++) begin
      exp_bw = (i % 2 == 0);
      tick();
      checks++;
      if (bw_gnt !== exp_bw || host_gnt !== !exp_bw) begin
        errors++;
        $display("FAIL fair_gnt%0d got bw=%b host=%b want bw=%b",
                 i, bw_gnt, host_gnt, exp_bw);
      end
      if (exp_bw) begin
        host_waddr = 16'h0200; host_reg_wen = 1;
      end else begin
        bw_waddr = 8'hF0; bw_reg_wen = 1;
      end
      tick();
      checks++;
      if (reg_wen !== 1'b0) begin
        errors++;
        $display("FAIL fair_nonowner%0d got reg_wen=%b want 0", i, reg_wen);
      end
      host_reg_wen = 0; bw_reg_wen = 0;
      if (exp_bw) begin
        bw_waddr = 8'h40 + 8'(i); bw_reg_wen = 1;
      end else begin
        host_waddr = 16'h0100 + 16'(i); host_reg_wen = 1;
      end
      tick();
      checks++;
      if (reg_wen !== 1'b1 ||
          reg_waddr !== (exp_bw ? 16'h0040 + 16'(i) : 16'h0100 + 16'(i))) begin
        errors++;
        $display("FAIL fair_write%0d got %b %h", i, reg_wen, reg_waddr);
      end
      host_reg_wen = 0; bw_reg_wen = 0;
      if (exp_bw) bw_req = 0; else host_req = 0;
      tick();
      checks++;
      if (bw_gnt !== 1'b0 || host_gnt !== 1'b0 || reg_wen !== 1'b0) begin
        errors++;
        $display("FAIL fair_turn%0d got bw=%b host=%b wen=%b want 000",
                 i, bw_gnt, host_gnt, reg_wen);
      end
      if (exp_bw) bw_req = 1; else host_req = 1;
      tick();
      checks++;
      if (bw_gnt !== 1'b0 || host_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fair_idle%0d got bw=%b host=%b want 00",
                 i, bw_gnt, host_gnt);
      end
    end
    host_req = 0; bw_req = 0;
    tick();
  endtask

  task automatic test_contention();
    rt_req = 1; bw_req = 1;
    tick();
    checks++;
    if (rt_gnt !== 1'b1 || bw_gnt !== 1'b0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL cont_rt_first got rt=%b bw=%b own=%0d want 1 0 3",
               rt_gnt, bw_gnt, owner);
    end
    rt_waddr = 4'h5; rt_wdata = 32'h1234_5678; rt_wen = 1;
    tick();
    checks++;
    if (reg_wen !== 1'b1 || reg_waddr !== 16'h0005 ||
        reg_wdata !== 32'h1234_5678 || blk_wen !== 1'b0) begin
      errors++;
      $display("FAIL cont_rt_write got %b %h %h %b want 1 0005 12345678 0",
               reg_wen, reg_waddr, reg_wdata, blk_wen);
    end
    rt_wen = 0; rt_req = 0;
    tick();
    checks++;
    if (rt_gnt !== 1'b0 || bw_gnt !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL cont_turn got rt=%b bw=%b own=%0d want 0 0 0",
               rt_gnt, bw_gnt, owner);
    end
    tick();
    tick();
    checks++;
    if (bw_gnt !== 1'b1 || bw_write_en !== 1'b1 || owner !== 2'd2) begin
      errors++;
      $display("FAIL cont_bw_gnt got %b %b %0d want 1 1 2",
               bw_gnt, bw_write_en, owner);
    end
    bw_waddr = 8'h23; bw_wdata = 32'hCAFE_0023; bw_reg_wen = 1;
    tick();
    checks++;
    if (reg_wen !== 1'b1 || reg_waddr !== 16'h0023 ||
        reg_wdata !== 32'hCAFE_0023) begin
      errors++;
      $display("FAIL cont_bw_addr got %b %h %h want 1 0023 cafe0023",
               reg_wen, reg_waddr, reg_wdata);
    end
    bw_reg_wen = 0; bw_req = 0;
    tick(); tick();
  endtask

  task automatic test_burst();
    logic [2:0] ev;
    bw_req = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      bw_blk_wstart = (k == 0);
      bw_reg_wen    = (k >= 1 && k <= 4);
      bw_blk_wen    = (k == 5);
      bw_waddr      = 8'h80 + 8'(k);
      bw_wdata      = 32'hB000_0000 + 32'(k);
      ev = {bw_blk_wstart, bw_reg_wen, bw_blk_wen};
      tick();
      checks++;
      if ({blk_wstart, reg_wen, blk_wen} !== ev ||
          reg_waddr !== 16'h0080 + 16'(k) ||
          reg_wdata !== 32'hB000_0000 + 32'(k) || bw_gnt !== 1'b1) begin
        errors++;
        $display("FAIL burst%0d got %b %h %h gnt=%b want %b", k,
                 {blk_wstart, reg_wen, blk_wen}, reg_waddr, reg_wdata,
                 bw_gnt, ev);
      end
    end
    bw_blk_wen = 0; bw_reg_wen = 0; bw_blk_wstart = 0;
    tick();
    checks++;
    if ({blk_wstart, reg_wen, blk_wen} !== 3'b000 || bw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL burst_end got %b gnt=%b want 000 1",
               {blk_wstart, reg_wen, blk_wen}, bw_gnt);
    end
    bw_req = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    host_req = 1;
    tick();
    for (int c = 1; c < 16; c++) begin
      tick();
      checks++;
      if (host_gnt !== 1'b1 || hold_timeout !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold%0d got gnt=%b flag=%b want 1 0",
                 c, host_gnt, hold_timeout);
      end
    end
    tick();
    checks++;
    if (host_gnt !== 1'b0 || hold_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire got gnt=%b flag=%b want 0 1",
               host_gnt, hold_timeout);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (host_gnt !== 1'b0) begin
        errors++;
        $display("FAIL tmo_nogrant%0d got %b want 0", c, host_gnt);
      end
    end
    host_req = 0;
    tick();
    host_req = 1;
    tick();
    checks++;
    if (host_gnt !== 1'b1 || hold_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_regrant got gnt=%b flag=%b want 1 1",
               host_gnt, hold_timeout);
    end
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    checks++;
    if (hold_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear got %b want 0", hold_timeout);
    end
    host_req = 0;
    tick(); tick();
  endtask

  task automatic test_reset_midburst();
    bw_req = 1;
    tick();
    bw_waddr = 8'h55; bw_reg_wen = 1;
    tick();
    checks++;
    if (reg_wen !== 1'b1 || bw_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got wen=%b gnt=%b want 1 1", reg_wen, bw_gnt);
    end
    rstn = 0;
    #1;
    checks++;
    if ({bw_gnt, bw_write_en, reg_wen, owner} !== 5'b0) begin
      errors++;
      $display("FAIL mid_async got %b want 00000",
               {bw_gnt, bw_write_en, reg_wen, owner});
    end
    bw_req = 0; bw_reg_wen = 0; rt_req = 1;
    #2;
    rstn = 1;
    tick();
    checks++;
    if (rt_gnt !== 1'b1 || owner !== 2'd3) begin
      errors++;
      $display("FAIL mid_rt_gnt got %b/%0d want 1/3", rt_gnt, owner);
    end
    rt_req = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_host();
    test_fairness();
    test_contention();
    test_burst();
    test_timeout();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbus_arbiter.md
Name: wbus_arbiter

Overview:
- Arbitrates the shared register write bus (reg_waddr/reg_wdata/reg_wen/blk_wen/blk_wstart) feeding the motor-controller register file.
- Three requesters share the bus: the host packet path (Firewire/Ethernet), the real-time block-write engine, and the real-time single-register writer.
- Sits between the FPGA module and the DQLA/QLA register consumers.
- Also generates bw_write_en, and reports bus-hold timeouts to the watchdog/status logic.

Parameters:
- HOLD_MAX, 4096: maximum sysclk cycles a granted owner may hold the bus without issuing any write strobe (about 83 us at 49.152 MHz).
- BW_ADDR_HI, 8'h00: upper address byte prepended to the 8-bit block-write address.
- RT_ADDR_HI, 12'h000: upper 12 address bits prepended to the 4-bit real-time address.

Ports:
- sysclk in 1: system clock, 49.152 MHz.
- rstn in 1: reset, asynchronous, active-low.
- host_req in 1, host_gnt out 1: host request / grant.
- host_waddr in 16, host_wdata in 32, host_reg_wen in 1, host_blk_wen in 1, host_blk_wstart in 1: host write bus.
- bw_req in 1, bw_gnt out 1: block-write request / grant.
- bw_waddr in 8, bw_wdata in 32, bw_reg_wen in 1, bw_blk_wen in 1, bw_blk_wstart in 1: block-write bus.
- rt_req in 1, rt_gnt out 1: real-time request / grant.
- rt_waddr in 4, rt_wdata in 32, rt_wen in 1: real-time write bus.
- reg_waddr out 16, reg_wdata out 32, reg_wen out 1, blk_wen out 1, blk_wstart out 1: arbitrated write bus.
- bw_write_en out 1: high while the block-write engine owns the bus.
- owner out 2: 0 = none, 1 = host, 2 = bw, 3 = rt.
- hold_timeout out 1: sticky timeout flag.
- timeout_clr in 1: clears hold_timeout.

Behaviour:
- Reset: all registered outputs go to 0 and the FSM goes to IDLE. The fairness bit (last_bw) and the drop_pending bits are cleared.
- FSM states: IDLE, OWN_HOST, OWN_BW, OWN_RT, TURN.
- IDLE: at most one grant per cycle, chosen among requesters whose drop_pending bit is clear.
  - rt_req has highest priority.
  - If both bw_req and host_req are pending, the one not served last wins (last_bw=1 means host wins).
  - If only one is pending, it wins.
  - The transition to OWN_x asserts x_gnt in the same registered cycle. With no request, stay in IDLE.
- OWN_x:
  - gnt stays high while x_req is high.
  - When x_req falls, go to TURN and drop gnt.
  - last_bw updates on entering OWN_BW (set to 1) or OWN_HOST (set to 0). OWN_RT does not change last_bw.
- TURN: exactly one cycle with the bus idle, then IDLE. Grant-to-grant gap is at least 2 cycles.
- Datapath:
  - Outputs are registered copies of the owner's inputs, so latency is 1 cycle from owner input to reg_* output.
  - Inputs are sampled only while in OWN_x with x_req high.
  - In all other states the strobes are 0, and addr/data hold their last value.
  - bw address = {BW_ADDR_HI, bw_waddr}.
  - rt address = {RT_ADDR_HI, rt_waddr}; rt_wen maps to reg_wen; rt never drives blk_wen or blk_wstart.
- Non-owners: their strobes are ignored and not queued. A requester must hold req until it sees gnt before driving strobes.
- Simultaneous strobes from the owner (e.g. reg_wen and blk_wen in the same cycle) are forwarded unchanged.
- bw_write_en = (state == OWN_BW), registered and aligned with bw_gnt.
- Hold counter:
  - Clears on entering OWN_x and on any owner strobe.
  - Increments otherwise in OWN_x and saturates.
  - When it reaches HOLD_MAX - 1 without a strobe: force TURN, drop gnt, set hold_timeout, set drop_pending[x].
- drop_pending[x] clears when x_req is low. That requester is not re-granted until it has deasserted req.
- hold_timeout: set dominates when set and timeout_clr occur in the same cycle.
- Reset asserted mid-burst: the grant drops immediately (asynchronously), and any in-flight strobe is lost. No partial-state recovery is required.

Decomposition:
- Shared constants file gets the owner encodings (OWN_NONE/HOST/BW/RT) and the FSM state encodings.
- One sub-module, wbus_hold_timer: counter with clear, saturate and terminal-count output, parameterized by HOLD_MAX.
- Mux and FSM stay in the top level.

Test Plan:
- Host only: host_req=1 → host_gnt=1 the next cycle. Host writes addr 16'h0012, data 32'hDEADBEEF with host_reg_wen pulse → reg_wen pulse one cycle later carrying the same addr/data, owner=1.
- Contention: rt_req and bw_req asserted in the same cycle from IDLE → rt_gnt first. After rt_req drops: 1 TURN cycle, then bw_gnt, bw_write_en=1, owner=2. bw_waddr 8'h23 → reg_waddr 16'h0023.
- Fairness: bw and host both request continuously, each releasing after one write → grants alternate bw, host, bw, host with a 2-cycle gap between grants. Non-owner strobes produce no reg_wen.
- Burst: bw sends blk_wstart, then 4 reg_wen, then blk_wen → outputs show the identical 6-event pattern delayed 1 cycle. Grant is held throughout.
- Timeout with HOLD_MAX=16: host granted, no strobes → at cycle 16 host_gnt=0 and hold_timeout=1. Host keeps req high → no re-grant. Host drops then re-raises req → granted. timeout_clr → flag 0.
- Reset mid-burst: rstn low during an OWN_BW burst → all grants and strobes 0 asynchronously, owner=0. After release, the FSM starts in IDLE and a pending rt_req is granted 1 cycle later.
